// File: rtl/wb_sad_reducer.sv
// Writeback-stage SAD reducer: 3-stage sum of absolute differences with running-minimum tracking.
// Optional macro SAD_CAND_COUNT_EN adds the CandCount output (completed candidates since reset/clear).
module wb_sad_reducer #(
    parameter int DATA_W = 32,
    parameter int LANES  = 16,
    parameter int SAD_W  = 36
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    ReadSpIn,
    input  logic [LANES*DATA_W-1:0] FrameBus,
    input  logic [LANES*DATA_W-1:0] WindowBus,
    input  logic [DATA_W-1:0]       BaseIn,
    input  logic [DATA_W-1:0]       RowIn,
    input  logic                    ClearMin,
    output logic                    SadValid,
    output logic [SAD_W-1:0]        SadOut,
    output logic [DATA_W-1:0]       SadBase,
    output logic [DATA_W-1:0]       SadRow,
    output logic [SAD_W-1:0]        MinSad,
    output logic [DATA_W-1:0]       MinBase,
    output logic [DATA_W-1:0]       MinRow,
    output logic                    MinValid
`ifdef SAD_CAND_COUNT_EN
    ,
    output logic [15:0]             CandCount
`endif
);

    localparam int PARTS = LANES / 4;
    localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};
    localparam logic [SAD_W-1:0]  ZERO_S = {SAD_W{1'b0}};
    localparam logic [SAD_W-1:0]  ONES_S = {SAD_W{1'b1}};

    function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic              s1_valid_r;
    logic [DATA_W-1:0] d_r [LANES];
    logic [DATA_W-1:0] s1_base_r;
    logic [DATA_W-1:0] s1_row_r;

    logic              s2_valid_r;
    logic [SAD_W-1:0]  part_s [PARTS];
    logic [SAD_W-1:0]  part_r [PARTS];
    logic [DATA_W-1:0] s2_base_r;
    logic [DATA_W-1:0] s2_row_r;

    logic [SAD_W-1:0]  sad_sum_s;
    logic              take_min_s;

    // Stage 1: per-lane absolute differences, captured with base/row
    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1_valid_r <= 1'b0;
            s1_base_r  <= ZERO_D;
            s1_row_r   <= ZERO_D;
            for (int i = 0; i < LANES; i++) begin
                d_r[i] <= ZERO_D;
            end
        end else begin
            s1_valid_r <= ReadSpIn;
            if (ReadSpIn) begin
                s1_base_r <= BaseIn;
                s1_row_r  <= RowIn;
                for (int i = 0; i < LANES; i++) begin
                    d_r[i] <= abs_diff(FrameBus[i*DATA_W +: DATA_W], WindowBus[i*DATA_W +: DATA_W]);
                end
            end
        end
    end

    // Groups of four adjacent differences, widened before adding
    always_comb begin
        for (int p = 0; p < PARTS; p++) begin
            part_s[p] = ZERO_S;
            for (int q = 0; q < 4; q++) begin
                part_s[p] = part_s[p] + SAD_W'(d_r[4*p + q]);
            end
        end
    end

    // Stage 2: partial-sum register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            s2_valid_r <= 1'b0;
            s2_base_r  <= ZERO_D;
            s2_row_r   <= ZERO_D;
            for (int p = 0; p < PARTS; p++) begin
                part_r[p] <= ZERO_S;
            end
        end else begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_base_r <= s1_base_r;
                s2_row_r  <= s1_row_r;
                for (int p = 0; p < PARTS; p++) begin
                    part_r[p] <= part_s[p];
                end
            end
        end
    end

    // Final reduction and the minimum-replacement decision (strict less keeps ties)
    always_comb begin
        sad_sum_s = ZERO_S;
        for (int p = 0; p < PARTS; p++) begin
            sad_sum_s = sad_sum_s + part_r[p];
        end
        if (s2_valid_r) begin
            take_min_s = ClearMin || !MinValid || (sad_sum_s < MinSad);
        end else begin
            take_min_s = 1'b0;
        end
    end

    // Stage 3: result outputs and running minimum
    always_ff @(posedge Clk) begin
        if (Rst) begin
            SadValid <= 1'b0;
            SadOut   <= ZERO_S;
            SadBase  <= ZERO_D;
            SadRow   <= ZERO_D;
            MinSad   <= ONES_S;
            MinBase  <= ZERO_D;
            MinRow   <= ZERO_D;
            MinValid <= 1'b0;
        end else begin
            SadValid <= s2_valid_r;
            if (s2_valid_r) begin
                SadOut  <= sad_sum_s;
                SadBase <= s2_base_r;
                SadRow  <= s2_row_r;
            end
            if (take_min_s) begin
                MinSad   <= sad_sum_s;
                MinBase  <= s2_base_r;
                MinRow   <= s2_row_r;
                MinValid <= 1'b1;
            end else if (ClearMin) begin
                MinSad   <= ONES_S;
                MinBase  <= ZERO_D;
                MinRow   <= ZERO_D;
                MinValid <= 1'b0;
            end
        end
    end

`ifdef SAD_CAND_COUNT_EN
    // Saturating count of completed candidates; a clear with a completion restarts at one
    always_ff @(posedge Clk) begin
        if (Rst) begin
            CandCount <= 16'h0000;
        end else if (s2_valid_r) begin
            if (ClearMin) begin
                CandCount <= 16'h0001;
            end else if (CandCount != 16'hFFFF) begin
                CandCount <= CandCount + 16'h0001;
            end
        end else if (ClearMin) begin
            CandCount <= 16'h0000;
        end
    end
`endif

endmodule

// File: tb/tb_wb_sad_reducer.sv
// Self-checking bench for wb_sad_reducer: directed scenarios plus randomized streams
// compared against a lane-by-lane arithmetic model of SAD and the running minimum.
module tb_wb_sad_reducer;

    localparam int DATA_W = 32;
    localparam int LANES  = 16;
    localparam int SAD_W  = 36;
    localparam int BUS_W  = LANES * DATA_W;
    localparam logic [SAD_W-1:0] ALL_ONES = {SAD_W{1'b1}};

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic              ReadSpIn = 1'b0;
    logic [BUS_W-1:0]  FrameBus = '0;
    logic [BUS_W-1:0]  WindowBus = '0;
    logic [DATA_W-1:0] BaseIn = '0;
    logic [DATA_W-1:0] RowIn = '0;
    logic              ClearMin = 1'b0;
    logic              SadValid;
    logic [SAD_W-1:0]  SadOut;
    logic [DATA_W-1:0] SadBase;
    logic [DATA_W-1:0] SadRow;
    logic [SAD_W-1:0]  MinSad;
    logic [DATA_W-1:0] MinBase;
    logic [DATA_W-1:0] MinRow;
    logic              MinValid;
`ifdef SAD_CAND_COUNT_EN
    logic [15:0]       CandCount;
`endif

    wb_sad_reducer #(.DATA_W(DATA_W), .LANES(LANES), .SAD_W(SAD_W)) dut (
        .Clk(Clk), .Rst(Rst), .ReadSpIn(ReadSpIn), .FrameBus(FrameBus), .WindowBus(WindowBus),
        .BaseIn(BaseIn), .RowIn(RowIn), .ClearMin(ClearMin), .SadValid(SadValid), .SadOut(SadOut),
        .SadBase(SadBase), .SadRow(SadRow), .MinSad(MinSad), .MinBase(MinBase), .MinRow(MinRow),
        .MinValid(MinValid)
`ifdef SAD_CAND_COUNT_EN
        , .CandCount(CandCount)
`endif
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus slots for one stream of consecutive cycles
    logic [BUS_W-1:0]  stim_f [32];
    logic [BUS_W-1:0]  stim_w [32];
    logic [DATA_W-1:0] stim_b [32];
    logic [DATA_W-1:0] stim_r [32];
    logic              stim_v [32];
    logic              stim_c [32];

    // Reference state
    logic              m_valid = 1'b0;
    logic [SAD_W-1:0]  m_sad   = {SAD_W{1'b1}};
    logic [DATA_W-1:0] m_base  = '0;
    logic [DATA_W-1:0] m_row   = '0;
    logic [15:0]       m_cnt   = 16'h0000;
    logic [SAD_W-1:0]  last_sad = '0;

    function automatic logic [SAD_W-1:0] ref_sad(input logic [BUS_W-1:0] f, input logic [BUS_W-1:0] w);
        longint acc, a, b, diff;
        acc = 0;
        for (int i = 0; i < LANES; i++) begin
            a = {32'd0, f[i*DATA_W +: DATA_W]};
            b = {32'd0, w[i*DATA_W +: DATA_W]};
            diff = a - b;
            if (diff < 0) diff = -diff;
            acc += diff;
        end
        return acc[SAD_W-1:0];
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < 32; i++) begin
            stim_f[i] = '0; stim_w[i] = '0; stim_b[i] = '0; stim_r[i] = '0;
            stim_v[i] = 1'b0; stim_c[i] = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_sad = ALL_ONES; m_base = '0; m_row = '0; m_cnt = 16'h0000;
    endtask

    // Drives n slots back to back, then drains; checks every cycle against the model
    task automatic run_stream(input int n);
        logic             prev_clr, exp_v;
        logic [SAD_W-1:0] exp_sad;
        int               j;
        prev_clr = 1'b0;
        for (int k = 0; k < n + 3; k++) begin
            @(negedge Clk);
            j = k - 3;
            exp_v = 1'b0;
            exp_sad = '0;
            if (j >= 0) begin
                exp_v = stim_v[j];
                exp_sad = ref_sad(stim_f[j], stim_w[j]);
            end
            if (exp_v && (prev_clr || !m_valid || exp_sad < m_sad)) begin
                m_valid = 1'b1; m_sad = exp_sad; m_base = stim_b[j]; m_row = stim_r[j];
            end else if (prev_clr) begin
                m_valid = 1'b0; m_sad = ALL_ONES; m_base = '0; m_row = '0;
            end
            if (exp_v) m_cnt = prev_clr ? 16'h0001 : ((m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'h0001);
            else if (prev_clr) m_cnt = 16'h0000;

            n_tests++;
            if (SadValid !== exp_v) begin n_fail++; $display("FAIL sad_valid cyc %0d: got %b expected %b", k, SadValid, exp_v); end
            if (exp_v) begin
                last_sad = SadOut;
                n_tests += 3;
                if (SadOut !== exp_sad) begin n_fail++; $display("FAIL sad_out cyc %0d: got %0h expected %0h", k, SadOut, exp_sad); end
                if (SadBase !== stim_b[j]) begin n_fail++; $display("FAIL sad_base cyc %0d: got %0h expected %0h", k, SadBase, stim_b[j]); end
                if (SadRow !== stim_r[j]) begin n_fail++; $display("FAIL sad_row cyc %0d: got %0h expected %0h", k, SadRow, stim_r[j]); end
            end
            n_tests += 4;
            if (MinValid !== m_valid) begin n_fail++; $display("FAIL min_valid cyc %0d: got %b expected %b", k, MinValid, m_valid); end
            if (MinSad !== m_sad) begin n_fail++; $display("FAIL min_sad cyc %0d: got %0h expected %0h", k, MinSad, m_sad); end
            if (MinBase !== m_base) begin n_fail++; $display("FAIL min_base cyc %0d: got %0h expected %0h", k, MinBase, m_base); end
            if (MinRow !== m_row) begin n_fail++; $display("FAIL min_row cyc %0d: got %0h expected %0h", k, MinRow, m_row); end
`ifdef SAD_CAND_COUNT_EN
            n_tests++;
            if (CandCount !== m_cnt) begin n_fail++; $display("FAIL cand_count cyc %0d: got %0d expected %0d", k, CandCount, m_cnt); end
`endif
            if (k < n) begin
                ReadSpIn = stim_v[k]; FrameBus = stim_f[k]; WindowBus = stim_w[k];
                BaseIn = stim_b[k]; RowIn = stim_r[k];
            end else begin
                ReadSpIn = 1'b0;
            end
            ClearMin = (k < n + 2) ? stim_c[k] : 1'b0;
            prev_clr = ClearMin;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            n_tests += 5;
            if (SadValid !== 1'b0) begin n_fail++; $display("FAIL reset_sad_valid: got %b expected 0", SadValid); end
            if (MinValid !== 1'b0) begin n_fail++; $display("FAIL reset_min_valid: got %b expected 0", MinValid); end
            if (MinSad !== 36'hF_FFFF_FFFF) begin n_fail++; $display("FAIL reset_min_sad: got %0h expected fffffffff", MinSad); end
            if (SadOut !== 36'h0) begin n_fail++; $display("FAIL reset_sad_out: got %0h expected 0", SadOut); end
            if (MinRow !== 32'h0) begin n_fail++; $display("FAIL reset_min_row: got %0h expected 0", MinRow); end
        end
    endtask

    task automatic test_basic();
        clear_stim();
        for (int i = 0; i < LANES; i++) begin
            stim_f[0][i*DATA_W +: DATA_W] = DATA_W'(i + 10);
            stim_w[0][i*DATA_W +: DATA_W] = 32'd10;
        end
        stim_b[0] = 32'h100; stim_r[0] = 32'd2; stim_v[0] = 1'b1;
        run_stream(1);
        n_tests += 4;
        if (last_sad !== 36'd120) begin n_fail++; $display("FAIL basic_sad: got %0d expected 120", last_sad); end
        if (MinSad !== 36'd120) begin n_fail++; $display("FAIL basic_min_sad: got %0d expected 120", MinSad); end
        if (MinBase !== 32'h100) begin n_fail++; $display("FAIL basic_min_base: got %0h expected 100", MinBase); end
        if (MinRow !== 32'd2) begin n_fail++; $display("FAIL basic_min_row: got %0d expected 2", MinRow); end
    endtask

    task automatic test_wide();
        clear_stim();
        stim_w[0] = {BUS_W{1'b1}}; stim_b[0] = 32'h200; stim_r[0] = 32'd7; stim_v[0] = 1'b1;
        run_stream(1);
        n_tests++;
        if (last_sad !== 36'hF_FFFF_FFF0) begin n_fail++; $display("FAIL wide_sad: got %0h expected ffffffff0", last_sad); end
    endtask

    task automatic test_back_to_back();
        int vals [4] = '{50, 30, 30, 70};
        clear_stim();
        for (int k = 0; k < 4; k++) begin
            stim_f[k][DATA_W-1:0] = DATA_W'(vals[k]);
            stim_b[k] = 32'h300 + DATA_W'(k); stim_r[k] = DATA_W'(k + 1); stim_v[k] = 1'b1;
        end
        run_stream(4);
        n_tests += 2;
        if (MinSad !== 36'd30) begin n_fail++; $display("FAIL b2b_min_sad: got %0d expected 30", MinSad); end
        if (MinRow !== 32'd2) begin n_fail++; $display("FAIL b2b_min_row: got %0d expected 2", MinRow); end
    endtask

    task automatic test_clear_min();
        clear_stim();
        stim_f[0][DATA_W-1:0] = 32'd90; stim_b[0] = 32'h400; stim_r[0] = 32'd9; stim_v[0] = 1'b1;
        stim_c[2] = 1'b1;
        run_stream(1);
        n_tests += 2;
        if (MinSad !== 36'd90) begin n_fail++; $display("FAIL clear_with_result_sad: got %0d expected 90", MinSad); end
        if (MinValid !== 1'b1) begin n_fail++; $display("FAIL clear_with_result_valid: got %b expected 1", MinValid); end
        clear_stim();
        stim_c[0] = 1'b1;
        run_stream(0);
        n_tests += 2;
        if (MinValid !== 1'b0) begin n_fail++; $display("FAIL clear_alone_valid: got %b expected 0", MinValid); end
        if (MinSad !== 36'hF_FFFF_FFFF) begin n_fail++; $display("FAIL clear_alone_sad: got %0h expected fffffffff", MinSad); end
    endtask

    task automatic test_random();
        for (int round = 0; round < 4; round++) begin
            clear_stim();
            for (int k = 0; k < 12; k++) begin
                for (int i = 0; i < LANES; i++) begin
                    stim_f[k][i*DATA_W +: DATA_W] = round[0] ? $urandom : $urandom_range(0, 7);
                    stim_w[k][i*DATA_W +: DATA_W] = round[0] ? $urandom : $urandom_range(0, 7);
                end
                if (k > 0 && $urandom_range(0, 3) == 0) begin
                    stim_f[k] = stim_f[k-1]; stim_w[k] = stim_w[k-1];
                end
                stim_b[k] = $urandom; stim_r[k] = $urandom;
                stim_v[k] = ($urandom_range(0, 4) != 0);
                stim_c[k] = ($urandom_range(0, 9) == 0);
            end
            run_stream(12);
        end
    endtask

    task automatic test_reset_mid();
        clear_stim();
        stim_f[0][DATA_W-1:0] = 32'd5; stim_b[0] = 32'h500; stim_r[0] = 32'd11; stim_v[0] = 1'b1;
        run_stream(1);
        @(negedge Clk);
        ReadSpIn = 1'b1; FrameBus = '0; WindowBus = {BUS_W{1'b1}}; BaseIn = 32'h600; RowIn = 32'd12;
        @(negedge Clk);
        ReadSpIn = 1'b0; Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            n_tests += 2;
            if (SadValid !== 1'b0) begin n_fail++; $display("FAIL midreset_sad_valid cyc %0d: got %b expected 0", k, SadValid); end
            if (MinValid !== 1'b0) begin n_fail++; $display("FAIL midreset_min_valid cyc %0d: got %b expected 0", k, MinValid); end
`ifdef SAD_CAND_COUNT_EN
            n_tests++;
            if (CandCount !== 16'h0000) begin n_fail++; $display("FAIL midreset_cand_count cyc %0d: got %0d expected 0", k, CandCount); end
`endif
        end
    endtask

    initial begin
        clear_stim();
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_wide();
        test_back_to_back();
        test_clear_min();
        test_random();
        test_reset_mid();
        test_basic();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
